// File: rtl/alu_dispatch_if.sv
// Handshake bundle between the instruction source, alu_dispatch and the ALU operand inputs.
// The slave modport is the dispatcher's view; master is the environment driving it.
interface alu_dispatch_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [2:0]  sel_alu;
  logic [4:0]  rd;
  logic        illegal;
  logic [31:0] dispatch_cnt;

  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, src1, src2, sel_alu, rd, illegal, dispatch_cnt
  );

  modport master (
    output in_valid, instr, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, src1, src2, sel_alu, rd, illegal, dispatch_cnt
  );
endinterface

// File: rtl/alu_dispatch.sv
// RV32I ALU op decoder with a two-entry (OUT + SKID) registered output buffer.
// Optional dispatch counter enabled by defining ALU_DISPATCH_PERF_EN.
module alu_dispatch (
  input  logic         clk,
  input  logic         rst,
  alu_dispatch_if.slave bus
);
  localparam int DATA_W = 32;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;
  localparam logic [2:0] SEL_XOR = 3'b100;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [2:0]        sel;
    logic [4:0]        rd;
    logic              illegal;
  } entry_t;

  function automatic entry_t decode(
    input logic [6:0]        opcode,
    input logic [2:0]        f3,
    input logic [6:0]        f7,
    input logic [11:0]       imm,
    input logic [4:0]        rd,
    input logic [DATA_W-1:0] rs1,
    input logic [DATA_W-1:0] rs2
  );
    entry_t                   e;
    logic                     legal;
    logic                     use_imm;
    logic [2:0]               sel;
    logic signed [DATA_W-1:0] imm_sx;
    e       = '0;
    legal   = 1'b0;
    use_imm = 1'b0;
    sel     = SEL_ADD;
    imm_sx  = {{(DATA_W-12){imm[11]}}, imm};
    case (opcode)
      7'b0110011: begin
        case (f3)
          3'b000: begin
            if (f7 == 7'b0000000) begin
              legal = 1'b1;
              sel   = SEL_ADD;
            end else if (f7 == 7'b0100000) begin
              legal = 1'b1;
              sel   = SEL_SUB;
            end
          end
          3'b100: begin legal = (f7 == 7'b0000000); sel = SEL_XOR; end
          3'b110: begin legal = (f7 == 7'b0000000); sel = SEL_OR;  end
          3'b111: begin legal = (f7 == 7'b0000000); sel = SEL_AND; end
          default: legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        use_imm = 1'b1;
        case (f3)
          3'b000: begin legal = 1'b1; sel = SEL_ADD; end
          3'b100: begin legal = 1'b1; sel = SEL_XOR; end
          3'b110: begin legal = 1'b1; sel = SEL_OR;  end
          3'b111: begin legal = 1'b1; sel = SEL_AND; end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    // Illegal entries still flow downstream, but with zeroed operands and ADD select.
    e.rd = rd;
    if (legal) begin
      e.src1 = rs1;
      e.src2 = use_imm ? imm_sx : rs2;
      e.sel  = sel;
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  state_e state_q, state_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   in_ready_q;
  logic   in_fire;
  logic   out_fire;
  logic   unused_rs1_idx;

  assign unused_rs1_idx = ^bus.instr[19:15];

  assign in_entry = decode(bus.instr[6:0], bus.instr[14:12], bus.instr[31:25],
                           bus.instr[31:20], bus.instr[11:7],
                           bus.rs1_data, bus.rs2_data);

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = (state_q != EMPTY) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          out_d   = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          out_d = in_entry;
        end else if (in_fire) begin
          skid_d  = in_entry;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Register stage: in_ready is precomputed from the next state so it never
  // depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      out_q      <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.src1      = out_q.src1;
  assign bus.src2      = out_q.src2;
  assign bus.sel_alu   = out_q.sel;
  assign bus.rd        = out_q.rd;
  assign bus.illegal   = out_q.illegal;

`ifdef ALU_DISPATCH_PERF_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_fire && !out_q.illegal) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.dispatch_cnt = cnt_q;
`else
  assign bus.dispatch_cnt = '0;
`endif
endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Operand/opcode producer for `alu_basic`. It accepts raw RV32I instruction words with their register-file read data over a valid/ready handshake. It decodes each word into the 3-bit ALU select and the two 32-bit operands, and presents them through a registered, skid-buffered output stage. Its outputs connect directly to the ALU's `src1`/`src2`/`sel_alu` inputs.

## Interface
- No parameters; all widths are fixed at RV32.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: instruction and read data are valid.
- `in_ready` out 1: block accepts an input this cycle.
- `instr` in 32: RV32I instruction word.
- `rs1_data` in 32: register-file value for `instr[19:15]`.
- `rs2_data` in 32: register-file value for `instr[24:20]`.
- `out_valid` out 1: output fields are valid.
- `out_ready` in 1: downstream accepts the output this cycle.
- `src1` out 32: ALU operand 1.
- `src2` out 32: ALU operand 2.
- `sel_alu` out 3: ALU select. Encoding: ADD 000, SUB 001, AND 010, OR 011, XOR 100.
- `rd` out 5: destination register, `instr[11:7]`.
- `illegal` out 1: instruction not supported by the ALU.
- `dispatch_cnt` out 32: count of dispatched ops; see Configuration.

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Decode for R-type (opcode 0110011):
  - f3=000, f7=0000000 → ADD
  - f3=000, f7=0100000 → SUB
  - f3=100 → XOR; f3=110 → OR; f3=111 → AND
  - `src2` = `rs2_data`
- Decode for I-type (opcode 0010011):
  - f3=000 → ADD; f3=100 → XOR; f3=110 → OR; f3=111 → AND
  - `src2` = sign-extended `instr[31:20]`; funct7 is ignored
- `src1` = `rs1_data` in all legal cases.
- The following are illegal:
  - any other opcode
  - f3 values 001, 010, 011, 101
  - R-type f3=000 with any f7 other than the two listed
  - R-type f3 ∈ {100, 110, 111} with f7 ≠ 0000000
- An illegal entry is still dispatched, with `illegal=1`, `sel_alu=000`, `src1=src2=0`, and `rd` as decoded. Downstream handles the trap.
- Storage is two entries: the output register (OUT) and a skid register (SKID). States:
  - EMPTY: OUT invalid, SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: OUT valid, SKID valid.
- `in_ready` = SKID invalid, driven directly from a register (no combinational path from `out_ready`).
- Transitions:
  - EMPTY + input → ONE.
  - ONE + input + output → ONE; the new entry goes to OUT.
  - ONE + input, no output → FULL; the new entry goes to SKID.
  - ONE + output, no input → EMPTY.
  - FULL + output → ONE; SKID moves to OUT. No input is possible in FULL.
- Entries leave in strict arrival order. No entry is dropped or duplicated.
- Output fields hold stable while `out_valid && !out_ready`.

## Timing
- Latency: an input accepted at edge N appears on the outputs at N+1 (one register stage).
- Throughput: 1 op/cycle while `out_ready` is held high.
- Stall at FULL: `in_ready` is low in the cycle after FULL is entered. It returns high in the cycle after the first output transfer from FULL.
- Reset values: while `rst` is high, `in_ready` = 0.
- Reset values, first cycle after `rst` deasserts: `in_ready`=1, `out_valid`=0, `src1`=0, `src2`=0, `sel_alu`=000, `rd`=0, `illegal`=0, `dispatch_cnt`=0.
- Reset mid-operation: on the reset edge, all buffered entries are discarded and no transfer completes on that edge.
- `out_valid` never depends combinationally on `in_valid`.

## Configuration
- Macro: `ALU_DISPATCH_PERF_EN`.
- Defined:
  - `dispatch_cnt` increments by 1 on each output transfer with `illegal=0`.
  - It wraps from 0xFFFFFFFF to 0.
  - It is cleared by `rst`.
- Undefined: the counter logic is omitted, and `dispatch_cnt` is tied to 0. The port list is identical in both builds.

## Test plan
- ADD: `instr`=0x002081B3 (add x3,x1,x2), `rs1`=5, `rs2`=7, `out_ready`=1 → next cycle `out_valid`=1, `sel_alu`=000, `src1`=5, `src2`=7, `rd`=3, `illegal`=0.
- SUB and immediate:
  - 0x402081B3 (sub) → `sel_alu`=001.
  - 0xFFF0C193 (xori x3,x1,-1) with `rs1`=0x0F → `sel_alu`=100, `src2`=0xFFFFFFFF.
- Illegal: 0x00209133 (sll) → `illegal`=1, `sel_alu`=000, `src1`=`src2`=0, `rd`=2.
  - With the macro defined, `dispatch_cnt` does not increment.
- Backpressure:
  - Hold `out_ready`=0 and send 3 valid ops A, B, C back-to-back → A and B are accepted, `in_ready` goes low, C waits.
  - Release `out_ready` → output order is A, B, C with no loss. `in_ready` rises one cycle after the first output transfer.
- Streaming: 100 random legal ops with `out_ready`=1 → one output per cycle, order preserved. With the macro defined, `dispatch_cnt`=100.
- Reset: assert `rst` while in FULL → next cycle `out_valid`=0 and `in_ready`=0. After deassertion, `in_ready`=1 and no stale entry is ever emitted.
